// File: rtl/multi_cycle_ctrl_if.sv
// Handshake bundle between the multi-cycle controller and its datapath:
// instruction fields and ALU flags in, datapath control strobes and selects out.
interface multi_cycle_ctrl_if #(
    parameter int ALU_CTRL_W = 3
);
    logic [6:0]            OPCODE;
    logic [2:0]            funct3;
    logic                  funct7;
    logic                  Zero;
    logic                  sign_flag;
    logic                  PCWrite;
    logic                  AdrSrc;
    logic                  MemWrite;
    logic                  IRWrite;
    logic                  RegWrite;
    logic [1:0]            ResultSrc;
    logic [1:0]            ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [ALU_CTRL_W-1:0] ALUControl;
    logic [1:0]            ImmSrc;
    logic                  Illegal;
    logic [3:0]            STATE;

    modport master (
        output OPCODE, funct3, funct7, Zero, sign_flag,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal, STATE
    );

    modport slave (
        input  OPCODE, funct3, funct7, Zero, sign_flag,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal, STATE
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RISC-V style main controller: Moore FSM with memory-latency dwell,
// a sticky illegal-instruction flag and a Mealy branch PCWrite.
module multi_cycle_ctrl #(
    parameter int ALU_CTRL_W = 3,
    parameter int MEM_LAT    = 0
) (
    input logic               CLK,
    input logic               RST,
    multi_cycle_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [3:0] LAT_LAST = 4'(MEM_LAT);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] wait_q;
    logic       illegal_q;
    logic       set_illegal;
    logic       dwell_done;
    logic       branch_ok;
    logic       branch_taken;
    logic [2:0] alu_op;
    logic [2:0] exec_alu;

    assign dwell_done = (wait_q == LAT_LAST);

    // The wait counter restarts whenever the state changes, so each memory
    // state sees 0..MEM_LAT on its own dwell regardless of where it came from.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_FETCH;
            wait_q    <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= (state_d != state_q) ? 4'd0 : wait_q + 4'd1;
            if (set_illegal)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        branch_ok    = 1'b1;
        branch_taken = 1'b0;
        case (bus.funct3)
            3'b000:  branch_taken = bus.Zero;
            3'b001:  branch_taken = !bus.Zero;
            3'b100:  branch_taken = bus.sign_flag;
            3'b101:  branch_taken = !bus.sign_flag;
            default: branch_ok    = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = S_FETCH;
        set_illegal = 1'b0;
        case (state_q)
            S_FETCH:    state_d = dwell_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.OPCODE)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_B:         state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d     = S_FETCH;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = (bus.OPCODE == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = dwell_done ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = dwell_done ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
            S_BRANCH: begin
                state_d     = S_FETCH;
                set_illegal = !branch_ok;
            end
            default:    state_d = S_FETCH;
        endcase
    end

    // funct7 only selects subtract for register-register ops; immediates always add.
    always_comb begin
        case (bus.funct3)
            3'b000:  exec_alu = (state_q == S_EXECR && bus.funct7) ? ALU_SUB : ALU_ADD;
            3'b010:  exec_alu = ALU_SLT;
            3'b100:  exec_alu = ALU_XOR;
            3'b110:  exec_alu = ALU_OR;
            3'b111:  exec_alu = ALU_AND;
            default: exec_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        bus.PCWrite   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        alu_op        = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = dwell_done;
                bus.PCWrite   = dwell_done;
            end
            S_DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
            end
            S_MEMREAD:  bus.AdrSrc = 1'b1;
            S_MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
            end
            S_EXECR: begin
                bus.ALUSrcA = 2'b10;
                alu_op      = exec_alu;
            end
            S_EXECI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                alu_op      = exec_alu;
            end
            S_ALUWB:    bus.RegWrite = 1'b1;
            S_BRANCH: begin
                bus.ALUSrcA = 2'b10;
                alu_op      = ALU_SUB;
                bus.PCWrite = branch_taken;
            end
            S_JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.PCWrite = 1'b1;
            end
            default: ;
        endcase
        // Reset must silence every write strobe even though state is still old.
        if (RST) begin
            bus.PCWrite  = 1'b0;
            bus.IRWrite  = 1'b0;
            bus.MemWrite = 1'b0;
            bus.RegWrite = 1'b0;
        end
    end

    always_comb begin
        bus.ALUControl      = '0;
        bus.ALUControl[2:0] = alu_op;
        case (bus.OPCODE)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_B:    bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end

    assign bus.Illegal = illegal_q;
    assign bus.STATE   = state_q;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: two instances (MEM_LAT 0 and 2) driven with directed
// and random instructions, checked against a per-instruction state-path model.
module tb_multi_cycle_ctrl;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic CLK = 1'b0;
    logic rst0 = 1'b1;
    logic rst2 = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   instr_no = 0;
    logic ill_m [2];
    int   path_st [$];
    bit   path_last [$];

    multi_cycle_ctrl_if #(.ALU_CTRL_W(3)) bus0 ();
    multi_cycle_ctrl_if #(.ALU_CTRL_W(5)) bus2 ();

    multi_cycle_ctrl #(.ALU_CTRL_W(3), .MEM_LAT(0)) dut0 (.CLK(CLK), .RST(rst0), .bus(bus0));
    multi_cycle_ctrl #(.ALU_CTRL_W(5), .MEM_LAT(2)) dut2 (.CLK(CLK), .RST(rst2), .bus(bus2));

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit legal_op(input logic [6:0] o);
        return (o == OP_LW || o == OP_SW || o == OP_R || o == OP_I || o == OP_B || o == OP_JAL);
    endfunction

    function automatic logic [7:0] exec_alu(input logic [2:0] f3, input logic f7, input bit is_r);
        case (f3)
            3'd0:    return (is_r && f7) ? 8'd1 : 8'd0;
            3'd2:    return 8'd5;
            3'd4:    return 8'd4;
            3'd6:    return 8'd3;
            3'd7:    return 8'd2;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic taken(input logic [2:0] f3, input logic z, input logic s);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return s;
            3'd5:    return !s;
            default: return 1'b0;
        endcase
    endfunction

    // Expected packed output word for one cycle, from the control table.
    function automatic logic [25:0] model_out(input int st, input bit last, input logic [6:0] opc,
                                              input logic [2:0] f3, input logic f7, input logic z,
                                              input logic s, input logic ill, input logic rst);
        logic pcw, irw, mw, rw, adr;
        logic [1:0] res, sa, sb, imm;
        logic [7:0] alu;
        logic [3:0] st4;
        pcw = 0; irw = 0; mw = 0; rw = 0; adr = 0;
        res = 0; sa = 0; sb = 0; alu = 0;
        st4 = 4'(st);
        case (st)
            0: begin sb = 2; res = 2; pcw = last; irw = last; end
            1: begin sa = 1; sb = 1; end
            2: begin sa = 2; sb = 1; end
            3: adr = 1;
            4: begin res = 1; rw = 1; end
            5: begin adr = 1; mw = 1; end
            6: begin sa = 2; alu = exec_alu(f3, f7, 1'b1); end
            7: begin sa = 2; sb = 1; alu = exec_alu(f3, f7, 1'b0); end
            8: rw = 1;
            9: begin sa = 2; alu = 8'd1; pcw = taken(f3, z, s); end
            10: begin sa = 1; sb = 2; pcw = 1; end
            default: ;
        endcase
        if (rst) begin pcw = 0; irw = 0; mw = 0; rw = 0; end
        imm = (opc == OP_SW) ? 2'd1 : (opc == OP_B) ? 2'd2 : (opc == OP_JAL) ? 2'd3 : 2'd0;
        return {st4, pcw, irw, mw, rw, adr, res, sa, sb, alu, imm, ill};
    endfunction

    function automatic logic [25:0] get_obs(input int sel);
        if (sel == 0)
            return {bus0.STATE, bus0.PCWrite, bus0.IRWrite, bus0.MemWrite, bus0.RegWrite, bus0.AdrSrc,
                    bus0.ResultSrc, bus0.ALUSrcA, bus0.ALUSrcB, 8'(bus0.ALUControl), bus0.ImmSrc, bus0.Illegal};
        return {bus2.STATE, bus2.PCWrite, bus2.IRWrite, bus2.MemWrite, bus2.RegWrite, bus2.AdrSrc,
                bus2.ResultSrc, bus2.ALUSrcA, bus2.ALUSrcB, 8'(bus2.ALUControl), bus2.ImmSrc, bus2.Illegal};
    endfunction

    task automatic applyStimulus(input int sel, input logic [6:0] o, input logic [2:0] f,
                                 input logic f7, input logic z, input logic s, input logic r);
        if (sel == 0) begin
            bus0.OPCODE = o; bus0.funct3 = f; bus0.funct7 = f7; bus0.Zero = z; bus0.sign_flag = s; rst0 = r;
        end else begin
            bus2.OPCODE = o; bus2.funct3 = f; bus2.funct7 = f7; bus2.Zero = z; bus2.sign_flag = s; rst2 = r;
        end
    endtask

    task automatic checkOutput(input int sel, input logic [25:0] exp, input string tag);
        logic [25:0] obs;
        obs = get_obs(sel);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int st, input int n);
        for (int i = 0; i < n; i++) begin
            path_st.push_back(st);
            path_last.push_back(i == n - 1);
        end
    endtask

    // zv/sv < 0 means randomise that flag every cycle; rst_at >= 0 aborts with reset there.
    task automatic run_instr(input int sel, input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                             input int zv, input int sv, input int rst_at);
        int lat;
        logic z, s;
        lat = (sel == 0) ? 0 : 2;
        instr_no++;
        path_st.delete();
        path_last.delete();
        push(0, lat + 1);
        push(1, 1);
        case (opc)
            OP_LW:  begin push(2, 1); push(3, lat + 1); push(4, 1); end
            OP_SW:  begin push(2, 1); push(5, lat + 1); end
            OP_R:   begin push(6, 1); push(8, 1); end
            OP_I:   begin push(7, 1); push(8, 1); end
            OP_B:   push(9, 1);
            OP_JAL: begin push(10, 1); push(8, 1); end
            default: ;
        endcase
        for (int i = 0; i < path_st.size(); i++) begin
            @(negedge CLK);
            z = (zv < 0) ? 1'($urandom % 2) : 1'(zv);
            s = (sv < 0) ? 1'($urandom % 2) : 1'(sv);
            applyStimulus(sel, opc, f3, f7, z, s, i == rst_at);
            #1;
            checkOutput(sel, model_out(path_st[i], path_last[i], opc, f3, f7, z, s, ill_m[sel], i == rst_at),
                        $sformatf("d%0d_i%0d_c%0d", sel, instr_no, i));
            if (i == rst_at) begin
                @(negedge CLK);
                #1;
                ill_m[sel] = 1'b0;
                checkOutput(sel, model_out(0, lat == 0, opc, f3, f7, z, s, 1'b0, 1'b1),
                            $sformatf("d%0d_i%0d_rst", sel, instr_no));
                return;
            end
            if (path_st[i] == 1 && !legal_op(opc)) ill_m[sel] = 1'b1;
            if (path_st[i] == 9 && !(f3 == 0 || f3 == 1 || f3 == 4 || f3 == 5)) ill_m[sel] = 1'b1;
        end
    endtask

    task automatic random_instr(input int sel);
        logic [6:0] o;
        case ($urandom_range(0, 7))
            0: o = OP_LW;
            1: o = OP_SW;
            2: o = OP_R;
            3: o = OP_I;
            4: o = OP_B;
            5: o = OP_JAL;
            default: o = 7'($urandom);
        endcase
        run_instr(sel, o, 3'($urandom), 1'($urandom), -1, -1, -1);
    endtask

    initial begin
        ill_m[0] = 1'b0;
        ill_m[1] = 1'b0;
        applyStimulus(0, OP_LW, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1, OP_LW, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) begin
            @(negedge CLK);
            #1;
            checkOutput(0, model_out(0, 1, OP_LW, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "reset_d0");
            checkOutput(1, model_out(0, 0, OP_LW, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "reset_d2");
        end

        $display("[TB] MEM_LAT=0 directed and random");
        run_instr(0, OP_LW, 3'd2, 1'b0, -1, -1, -1);
        run_instr(0, OP_R, 3'd0, 1'b1, -1, -1, -1);
        run_instr(0, OP_R, 3'd7, 1'b0, -1, -1, -1);
        run_instr(0, OP_I, 3'd0, 1'b1, -1, -1, -1);
        run_instr(0, OP_B, 3'd4, 1'b0, 0, 1, -1);
        run_instr(0, OP_B, 3'd4, 1'b0, 0, 0, -1);
        run_instr(0, OP_B, 3'd1, 1'b0, 0, 0, -1);
        run_instr(0, OP_B, 3'd0, 1'b0, 1, 0, -1);
        run_instr(0, OP_JAL, 3'd0, 1'b0, -1, -1, -1);
        run_instr(0, OP_SW, 3'd2, 1'b0, -1, -1, -1);
        for (int k = 0; k < 40; k++) random_instr(0);
        run_instr(0, OP_B, 3'd2, 1'b0, -1, -1, -1);
        run_instr(0, 7'b1111111, 3'd0, 1'b0, -1, -1, -1);
        run_instr(0, OP_LW, 3'd2, 1'b0, -1, -1, -1);
        run_instr(0, OP_R, 3'd6, 1'b0, -1, -1, -1);

        @(negedge CLK);
        rst0 = 1'b1;
        $display("[TB] MEM_LAT=2 directed and random");
        run_instr(1, OP_SW, 3'd2, 1'b0, -1, -1, -1);
        run_instr(1, OP_LW, 3'd2, 1'b0, -1, -1, -1);
        for (int k = 0; k < 30; k++) random_instr(1);
        run_instr(1, 7'b1111111, 3'd0, 1'b0, -1, -1, -1);
        run_instr(1, OP_R, 3'd4, 1'b0, -1, -1, -1);
        run_instr(1, OP_LW, 3'd2, 1'b0, -1, -1, 6);
        run_instr(1, OP_LW, 3'd2, 1'b0, -1, -1, -1);
        run_instr(1, OP_I, 3'd2, 1'b0, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
